// File: rtl/mdio_pkg.sv
// Shared constants and FSM state type for the Clause-22 MDIO PHY responder.
package mdio_pkg;

   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   localparam logic [4:0] REG_BMCR = 5'd0;
   localparam logic [4:0] REG_BMSR = 5'd1;
   localparam logic [4:0] REG_ID1  = 5'd2;
   localparam logic [4:0] REG_ID2  = 5'd3;
   localparam logic [4:0] REG_GBCR = 5'd9;

   localparam int unsigned BMCR_SOFT_RESET = 15;
   localparam int unsigned BMCR_AN_RESTART = 9;
   localparam int unsigned BMSR_LINK       = 2;

   localparam logic [15:0] BMCR_DEFAULT = 16'h1140;
   localparam logic [15:0] BMCR_SC_MASK = 16'h8200;
   localparam logic [15:0] BMSR_VALUE   = 16'h7949;

   typedef enum logic [2:0] {
      S_PRE,
      S_ST2,
      S_OP,
      S_PHYAD,
      S_REGAD,
      S_TA,
      S_DATA
   } mdio_state_e;

endpackage

// File: rtl/mdio_phy_regfile.sv
// 32x16 PHY management register file: defaults, read-only regs, self-clearing
// BMCR bits, soft reset and live link status.
module mdio_phy_regfile
   import mdio_pkg::*;
#(
   parameter logic [15:0] PHY_ID1      = 16'h001C,
   parameter logic [15:0] PHY_ID2      = 16'hC916,
   parameter logic [15:0] REG9_DEFAULT = 16'h0300
) (
   input  logic        clk_i,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [15:0] wdata_i,
   input  logic [4:0]  raddr_i,
   input  logic        link_up_i,
   output logic [15:0] rdata_o
);

   logic [15:0] mem_q [32];
   logic        soft_rst;
   logic        writable;
   logic [15:0] wr_val;

   function automatic logic [15:0] reset_value(input logic [4:0] idx);
      case (idx)
         REG_BMCR: return BMCR_DEFAULT;
         REG_GBCR: return REG9_DEFAULT;
         default:  return '0;
      endcase
   endfunction

   assign soft_rst = we_i && (waddr_i == REG_BMCR) && wdata_i[BMCR_SOFT_RESET];
   assign writable = !(waddr_i inside {REG_BMSR, REG_ID1, REG_ID2});

   // Self-clearing BMCR bits are never stored, so they always read back as 0.
   always_comb begin
      wr_val = wdata_i;
      if (waddr_i == REG_BMCR) wr_val = wdata_i & ~BMCR_SC_MASK;
   end

   always_ff @(posedge clk_i) begin
      if (rst || soft_rst) begin
         for (int unsigned i = 0; i < 32; i++) mem_q[i] <= reset_value(5'(i));
      end else if (we_i && writable) begin
         mem_q[waddr_i] <= wr_val;
      end
   end

   always_comb begin
      rdata_o = mem_q[raddr_i];
      case (raddr_i)
         REG_BMSR: begin
            rdata_o            = BMSR_VALUE;
            rdata_o[BMSR_LINK] = link_up_i;
         end
         REG_ID1: rdata_o = PHY_ID1;
         REG_ID2: rdata_o = PHY_ID2;
         default: ;
      endcase
   end

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: oversamples MDC/MDIO on clk_i, decodes
// frames for PHY_ADDR and serves them from mdio_phy_regfile.
module mdio_phy_responder
   import mdio_pkg::*;
#(
   parameter logic [4:0]  PHY_ADDR     = 5'h00,
   parameter int unsigned PREAMBLE_LEN = 32,
   parameter logic [15:0] PHY_ID1      = 16'h001C,
   parameter logic [15:0] PHY_ID2      = 16'hC916,
   parameter logic [15:0] REG9_DEFAULT = 16'h0300
) (
   input  logic        clk_i,
   input  logic        rst,
   input  logic        mdc_i,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_t,
   input  logic        link_up_i,
   output logic        reg_wr_valid,
   output logic [4:0]  reg_wr_addr,
   output logic [15:0] reg_wr_data,
   output logic        an_restart_o,
   output logic        busy_o
);

   logic mdc_s1_q, mdc_s2_q, mdc_prev_q, mdio_s1_q, mdio_s2_q;
   logic mdc_rise, bit_in;

   mdio_state_e state_q, state_d;
   logic [5:0]  pre_cnt_q, pre_cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [3:0]  sh_q, sh_d;
   logic [1:0]  op_q, op_d;
   logic        match_q, match_d;
   logic [4:0]  regad_q, regad_d;
   logic [14:0] wsr_q, wsr_d;
   logic [15:0] rsr_q, rsr_d;
   logic        mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
   logic        wr_valid_q, wr_valid_d, an_q, an_d;
   logic [4:0]  wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;

   logic        rf_we;
   logic [4:0]  rf_raddr;
   logic [15:0] rf_wdata, rf_rdata;
   logic        is_rd, is_wr;

   assign mdc_rise = mdc_s2_q & ~mdc_prev_q;
   assign bit_in   = mdio_s2_q;
   assign rf_raddr = {sh_q, bit_in};
   assign rf_wdata = {wsr_q, bit_in};
   assign is_rd    = match_q && (op_q == OP_READ);
   assign is_wr    = match_q && (op_q == OP_WRITE);

   mdio_phy_regfile #(
      .PHY_ID1      (PHY_ID1),
      .PHY_ID2      (PHY_ID2),
      .REG9_DEFAULT (REG9_DEFAULT)
   ) u_regfile (
      .clk_i     (clk_i),
      .rst       (rst),
      .we_i      (rf_we),
      .waddr_i   (regad_q),
      .wdata_i   (rf_wdata),
      .raddr_i   (rf_raddr),
      .link_up_i (link_up_i),
      .rdata_o   (rf_rdata)
   );

   // Synchronizers keep running through reset so no false MDC edge appears on release.
   always_ff @(posedge clk_i) begin
      mdc_s1_q   <= mdc_i;
      mdc_s2_q   <= mdc_s1_q;
      mdc_prev_q <= mdc_s2_q;
      mdio_s1_q  <= mdio_i;
      mdio_s2_q  <= mdio_s1_q;
      if (rst) begin
         state_q    <= S_PRE;
         pre_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         sh_q       <= '0;
         op_q       <= '0;
         match_q    <= 1'b0;
         regad_q    <= '0;
         wsr_q      <= '0;
         rsr_q      <= '0;
         mdio_o_q   <= 1'b0;
         mdio_t_q   <= 1'b1;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         an_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         op_q       <= op_d;
         match_q    <= match_d;
         regad_q    <= regad_d;
         wsr_q      <= wsr_d;
         rsr_q      <= rsr_d;
         mdio_o_q   <= mdio_o_d;
         mdio_t_q   <= mdio_t_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         an_q       <= an_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pre_cnt_d  = pre_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      op_d       = op_q;
      match_d    = match_q;
      regad_d    = regad_q;
      wsr_d      = wsr_q;
      rsr_d      = rsr_q;
      mdio_o_d   = mdio_o_q;
      mdio_t_d   = mdio_t_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      an_d       = 1'b0;
      rf_we      = 1'b0;

      if (mdc_rise) begin
         case (state_q)
            S_PRE: begin
               if (bit_in) begin
                  if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
               end else begin
                  pre_cnt_d = '0;
                  if (pre_cnt_q >= 6'(PREAMBLE_LEN)) state_d = S_ST2;
               end
            end
            S_ST2: begin
               bit_cnt_d = '0;
               state_d   = bit_in ? S_OP : S_PRE;
            end
            S_OP: begin
               op_d      = {op_q[0], bit_in};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd1) begin
                  bit_cnt_d = '0;
                  state_d   = (op_d == OP_WRITE || op_d == OP_READ) ? S_PHYAD : S_PRE;
               end
            end
            S_PHYAD: begin
               sh_d      = {sh_q[2:0], bit_in};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd4) begin
                  match_d   = ({sh_q, bit_in} == PHY_ADDR);
                  bit_cnt_d = '0;
                  state_d   = S_REGAD;
               end
            end
            S_REGAD: begin
               sh_d      = {sh_q[2:0], bit_in};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd4) begin
                  regad_d   = rf_raddr;
                  rsr_d     = rf_rdata;
                  bit_cnt_d = '0;
                  state_d   = S_TA;
               end
            end
            S_TA: begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd0) begin
                  if (is_rd) begin
                     mdio_t_d = 1'b0;
                     mdio_o_d = 1'b0;
                  end
               end else begin
                  if (is_rd) begin
                     mdio_o_d = rsr_q[15];
                     rsr_d    = {rsr_q[14:0], 1'b0};
                  end
                  bit_cnt_d = '0;
                  state_d   = S_DATA;
               end
            end
            S_DATA: begin
               wsr_d     = {wsr_q[13:0], bit_in};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q != 4'd15) begin
                  if (is_rd) begin
                     mdio_o_d = rsr_q[15];
                     rsr_d    = {rsr_q[14:0], 1'b0};
                  end
               end else begin
                  mdio_t_d  = 1'b1;
                  mdio_o_d  = 1'b0;
                  bit_cnt_d = '0;
                  pre_cnt_d = '0;
                  state_d   = S_PRE;
                  if (is_wr) begin
                     rf_we      = 1'b1;
                     wr_valid_d = 1'b1;
                     wr_addr_d  = regad_q;
                     wr_data_d  = rf_wdata;
                     an_d       = (regad_q == REG_BMCR) && rf_wdata[BMCR_AN_RESTART];
                  end
               end
            end
            default: state_d = S_PRE;
         endcase
      end
   end

   assign mdio_o       = mdio_o_q;
   assign mdio_t       = mdio_t_q;
   assign reg_wr_valid = wr_valid_q;
   assign reg_wr_addr  = wr_addr_q;
   assign reg_wr_data  = wr_data_q;
   assign an_restart_o = an_q;
   assign busy_o       = (state_q != S_PRE);

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed self-checking bench for mdio_phy_responder: bit-banged MDC/MDIO frames
// with hand-computed register values.
module tb_mdio_phy_responder;

   logic        clk_i = 1'b0;
   logic        rst;
   logic        mdc_i;
   logic        mdio_i;
   logic        mdio_o;
   logic        mdio_t;
   logic        link_up_i;
   logic        reg_wr_valid;
   logic [4:0]  reg_wr_addr;
   logic [15:0] reg_wr_data;
   logic        an_restart_o;
   logic        busy_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned wr_cnt   = 0;
   int unsigned an_cnt   = 0;
   logic [4:0]  last_wr_addr = '0;
   logic [15:0] last_wr_data = '0;

   // frame results
   logic [15:0] r_data;
   logic        r_tta1, r_tta2, r_ota2, r_drv_all, r_drv_any, r_rel, r_busy;

   always #4 clk_i = ~clk_i;

   mdio_phy_responder #(
      .PHY_ADDR     (5'h00),
      .PREAMBLE_LEN (32),
      .PHY_ID1      (16'h001C),
      .PHY_ID2      (16'hC916),
      .REG9_DEFAULT (16'h0300)
   ) dut (
      .clk_i        (clk_i),
      .rst          (rst),
      .mdc_i        (mdc_i),
      .mdio_i       (mdio_i),
      .mdio_o       (mdio_o),
      .mdio_t       (mdio_t),
      .link_up_i    (link_up_i),
      .reg_wr_valid (reg_wr_valid),
      .reg_wr_addr  (reg_wr_addr),
      .reg_wr_data  (reg_wr_data),
      .an_restart_o (an_restart_o),
      .busy_o       (busy_o)
   );

   always @(negedge clk_i) begin
      if (reg_wr_valid) begin
         wr_cnt       = wr_cnt + 1;
         last_wr_addr = reg_wr_addr;
         last_wr_data = reg_wr_data;
      end
      if (an_restart_o) an_cnt = an_cnt + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One MDC period: drive bit on the low phase, sample outputs just before the rise.
   task automatic mdc_cycle(input logic b, output logic t_s, output logic o_s);
      mdio_i = b;
      mdc_i  = 1'b0;
      repeat (4) @(negedge clk_i);
      t_s   = mdio_t;
      o_s   = mdio_o;
      mdc_i = 1'b1;
      repeat (4) @(negedge clk_i);
      mdc_i = 1'b0;
   endtask

   task automatic frame(input int unsigned pre_len, input logic [1:0] op, input logic [4:0] pa,
                        input logic [4:0] ra, input logic [15:0] wd, input int abort_idx);
      logic [31:0] bits;
      logic        t, o;
      bits = {2'b01, op, pa, ra, (op == 2'b10) ? 2'b11 : 2'b10, (op == 2'b10) ? 16'hFFFF : wd};
      r_data = '0; r_tta1 = 1'b0; r_tta2 = 1'b1; r_ota2 = 1'b1;
      r_drv_all = 1'b1; r_drv_any = 1'b0; r_rel = 1'b0; r_busy = 1'b0;
      for (int i = 0; i < int'(pre_len); i++) mdc_cycle(1'b1, t, o);
      for (int i = 0; i < 32; i++) begin
         if (i == abort_idx) begin
            mdio_i = 1'b1;
            repeat (4) @(negedge clk_i);
            check("drv_before_rst", {31'd0, mdio_t}, 32'd0);
            rst = 1'b1;
            @(negedge clk_i);
            check("rel_after_rst", {31'd0, mdio_t}, 32'd1);
            mdc_i = 1'b1;
            repeat (4) @(negedge clk_i);
            mdc_i = 1'b0;
            repeat (4) @(negedge clk_i);
            rst = 1'b0;
            repeat (4) @(negedge clk_i);
            check("busy_after_rst", {31'd0, busy_o}, 32'd0);
            return;
         end
         mdc_cycle(bits[31-i], t, o);
         if (i == 14) r_tta1 = t;
         if (i == 15) begin r_tta2 = t; r_ota2 = o; end
         if (i >= 16) begin r_data[31-i] = o; r_drv_all &= ~t; end
         r_drv_any |= ~t;
         if (i == 20) r_busy = busy_o;
      end
      mdio_i = 1'b1;
      repeat (4) @(negedge clk_i);
      r_rel = mdio_t;
   endtask

   task automatic rd_reg(input logic [4:0] pa, input logic [4:0] ra);
      frame(32, 2'b10, pa, ra, 16'h0000, -1);
   endtask

   task automatic wr_reg(input int unsigned pre, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] d);
      frame(pre, 2'b01, pa, ra, d, -1);
   endtask

   initial begin
      int unsigned c0;
      rst = 1'b1; mdc_i = 1'b0; mdio_i = 1'b1; link_up_i = 1'b0;
      repeat (6) @(negedge clk_i);
      rst = 1'b0;
      @(negedge clk_i);
      check("rst_mdio_t", {31'd0, mdio_t}, 32'd1);
      check("rst_mdio_o", {31'd0, mdio_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_wr_valid", {31'd0, reg_wr_valid}, 32'd0);
      check("rst_an", {31'd0, an_restart_o}, 32'd0);

      rd_reg(5'h00, 5'd2);
      check("r2_ta1_released", {31'd0, r_tta1}, 32'd1);
      check("r2_ta2_driven", {31'd0, r_tta2}, 32'd0);
      check("r2_ta2_zero", {31'd0, r_ota2}, 32'd0);
      check("r2_data", {16'd0, r_data}, 32'h001C);
      check("r2_drv_all", {31'd0, r_drv_all}, 32'd1);
      check("r2_released", {31'd0, r_rel}, 32'd1);
      check("r2_busy", {31'd0, r_busy}, 32'd1);

      rd_reg(5'h00, 5'd9);
      check("r9_default", {16'd0, r_data}, 32'h0300);

      c0 = wr_cnt;
      wr_reg(32, 5'h00, 5'd9, 16'h0000);
      check("w9_pulses", wr_cnt - c0, 32'd1);
      check("w9_addr", {27'd0, last_wr_addr}, 32'd9);
      check("w9_data", {16'd0, last_wr_data}, 32'h0000);
      rd_reg(5'h00, 5'd9);
      check("r9_after_w", {16'd0, r_data}, 32'h0000);

      c0 = wr_cnt;
      wr_reg(32, 5'h00, 5'd0, 16'h1340);
      check("w0_an_pulses", an_cnt, 32'd1);
      check("w0_pulses", wr_cnt - c0, 32'd1);
      check("w0_data", {16'd0, last_wr_data}, 32'h1340);
      rd_reg(5'h00, 5'd0);
      check("r0_selfclear", {16'd0, r_data}, 32'h1140);

      rd_reg(5'h03, 5'd2);
      check("mis_rd_never_drv", {31'd0, r_drv_any}, 32'd0);
      c0 = wr_cnt;
      wr_reg(32, 5'h03, 5'd9, 16'hBEEF);
      check("mis_wr_no_pulse", wr_cnt - c0, 32'd0);
      rd_reg(5'h00, 5'd9);
      check("mis_wr_unchanged", {16'd0, r_data}, 32'h0000);

      c0 = wr_cnt;
      wr_reg(31, 5'h00, 5'd16, 16'hA5A5);
      check("pre31_no_pulse", wr_cnt - c0, 32'd0);
      rd_reg(5'h00, 5'd16);
      check("pre31_unchanged", {16'd0, r_data}, 32'h0000);
      c0 = wr_cnt;
      wr_reg(32, 5'h00, 5'd16, 16'hA5A5);
      check("pre32_pulse", wr_cnt - c0, 32'd1);
      rd_reg(5'h00, 5'd16);
      check("pre32_written", {16'd0, r_data}, 32'hA5A5);

      rd_reg(5'h00, 5'd1);
      check("r1_link_down", {16'd0, r_data}, 32'h7949);
      link_up_i = 1'b1;
      rd_reg(5'h00, 5'd1);
      check("r1_link_up", {16'd0, r_data}, 32'h794D);

      rd_reg(5'h00, 5'd3);
      check("r3_id2", {16'd0, r_data}, 32'hC916);
      c0 = wr_cnt;
      wr_reg(32, 5'h00, 5'd2, 16'h1234);
      check("w2_ro_pulse", wr_cnt - c0, 32'd1);
      rd_reg(5'h00, 5'd2);
      check("w2_ro_unchanged", {16'd0, r_data}, 32'h001C);

      wr_reg(32, 5'h00, 5'd0, 16'h8000);
      rd_reg(5'h00, 5'd16);
      check("softrst_r16", {16'd0, r_data}, 32'h0000);
      rd_reg(5'h00, 5'd9);
      check("softrst_r9", {16'd0, r_data}, 32'h0300);
      rd_reg(5'h00, 5'd0);
      check("softrst_r0", {16'd0, r_data}, 32'h1140);
      check("an_total", an_cnt, 32'd1);

      frame(32, 2'b10, 5'h00, 5'd3, 16'h0000, 23);
      rd_reg(5'h00, 5'd2);
      check("post_rst_r2", {16'd0, r_data}, 32'h001C);
      check("post_rst_released", {31'd0, r_rel}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
